// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, state encoding and helpers for the compression core.
package sha1_pkg;

  localparam logic [31:0] SHA1_K0 = 32'h5A827999;
  localparam logic [31:0] SHA1_K1 = 32'h6ED9EBA1;
  localparam logic [31:0] SHA1_K2 = 32'h8F1BBCDC;
  localparam logic [31:0] SHA1_K3 = 32'hCA62C1D6;

  localparam logic [159:0] SHA1_IV =
    160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  // Round index at which each f/K range begins, plus the last round and the
  // finalize slot that follows it.
  localparam logic [6:0] RND_PARITY1 = 7'd20;
  localparam logic [6:0] RND_MAJ     = 7'd40;
  localparam logic [6:0] RND_PARITY2 = 7'd60;
  localparam logic [6:0] RND_FINAL   = 7'd80;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } state_e;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sha1_exec_core_round.sv
// Combinational single SHA-1 round: selects f/K from the round index and
// produces the next working variables.
module sha1_round
  import sha1_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] e_i,
  input  logic [31:0] w_i,
  input  logic [6:0]  round_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic [31:0] e_o
);

  logic [31:0] f;
  logic [31:0] k;

  // Round function and constant selection by round range.
  always_comb begin
    f = '0;
    k = '0;
    if (round_i < RND_PARITY1) begin
      f = (b_i & c_i) | (~b_i & d_i);
      k = SHA1_K0;
    end else if (round_i < RND_MAJ) begin
      f = b_i ^ c_i ^ d_i;
      k = SHA1_K1;
    end else if (round_i < RND_PARITY2) begin
      f = (b_i & c_i) | (b_i & d_i) | (c_i & d_i);
      k = SHA1_K2;
    end else begin
      f = b_i ^ c_i ^ d_i;
      k = SHA1_K3;
    end
  end

  // Working-variable rotation for one round.
  always_comb begin
    a_o = rotl(a_i, 5) + f + e_i + k + w_i;
    b_o = a_i;
    c_o = rotl(b_i, 30);
    d_o = c_i;
    e_o = d_i;
  end

endmodule

// File: rtl/sha1_exec_core.sv
// Iterative SHA-1 compression: 16-word message buffer, one round per clock,
// lane-wise chaining-value addition on the edge after round 79.
module sha1_exec_core
  import sha1_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  data_in,
  input  logic         load_in,
  input  logic         start,
  input  logic [159:0] cv,
  input  logic         use_prev_cv,
  output logic         busy,
  output logic         out_valid,
  output logic [159:0] cv_next
);

  state_e       state_q, state_d;
  logic [6:0]   rnd_q, rnd_d;
  logic [159:0] cv_q, cv_d;
  logic [159:0] cv_next_q, cv_next_d;
  logic [31:0]  a_q, b_q, c_q, d_q, e_q;
  logic [31:0]  a_d, b_d, c_d, d_d, e_d;
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;

  logic [31:0]  ra, rb, rc, rd, re;
  logic [31:0]  w_new;
  logic [159:0] cv_sel;
  logic [159:0] work;

  sha1_round u_round (
    .a_i     (a_q),
    .b_i     (b_q),
    .c_i     (c_q),
    .d_i     (d_q),
    .e_i     (e_q),
    .w_i     (w_q[0]),
    .round_i (rnd_q),
    .a_o     (ra),
    .b_o     (rb),
    .c_o     (rc),
    .d_o     (rd),
    .e_o     (re)
  );

  // Message schedule: with the head at W[t], taps 13/8/2/0 give
  // W[t+13], W[t+8], W[t+2], W[t], i.e. the inputs for W[t+16].
  always_comb begin
    w_new  = rotl(w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0], 1);
    cv_sel = use_prev_cv ? cv_next_q : cv;
    work   = {a_q, b_q, c_q, d_q, e_q};
  end

  // Next-state logic for the load / round / finalize sequence.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    cv_d      = cv_q;
    cv_next_d = cv_next_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    d_d       = d_q;
    e_d       = e_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    for (int unsigned i = 0; i < 16; i++) w_d[i] = w_q[i];

    case (state_q)
      IDLE: begin
        if (load_in) begin
          for (int unsigned i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
          w_d[15] = data_in;
        end
        if (start) begin
          cv_d    = cv_sel;
          {a_d, b_d, c_d, d_d, e_d} = cv_sel;
          rnd_d   = '0;
          busy_d  = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        // Counter values 0..79 are rounds; 80 is the finalize slot, kept in
        // this state so the FSM stays two-state.
        if (rnd_q != RND_FINAL) begin
          a_d = ra;
          b_d = rb;
          c_d = rc;
          d_d = rd;
          e_d = re;
          for (int unsigned i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
          w_d[15] = w_new;
          rnd_d   = rnd_q + 7'd1;
        end else begin
          for (int unsigned i = 0; i < 5; i++)
            cv_next_d[32*i +: 32] = cv_q[32*i +: 32] + work[32*i +: 32];
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rnd_q     <= '0;
      cv_q      <= '0;
      cv_next_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      e_q       <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      cv_q      <= cv_d;
      cv_next_q <= cv_next_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      d_q       <= d_d;
      e_q       <= e_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= w_d[i];
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign cv_next   = cv_next_q;

endmodule

// File: tb/tb_sha1_exec_core.sv
// Directed bench for sha1_exec_core: table of known-answer blocks plus
// hand-written sequences for ignored start/load, mid-run reset and timing.
module tb_sha1_exec_core;
  import sha1_pkg::*;

  logic         clk;
  logic         reset;
  logic [31:0]  data_in;
  logic         load_in;
  logic         start;
  logic [159:0] cv;
  logic         use_prev_cv;
  logic         busy;
  logic         out_valid;
  logic [159:0] cv_next;

  int n_vec  = 0;
  int n_fail = 0;

  sha1_exec_core dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .load_in     (load_in),
    .start       (start),
    .cv          (cv),
    .use_prev_cv (use_prev_cv),
    .busy        (busy),
    .out_valid   (out_valid),
    .cv_next     (cv_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [511:0] blk;
    logic [159:0] cv;
    logic         use_prev;
    logic         chk;
    logic [159:0] expd;
  } vec_t;

  localparam logic [159:0] DIG_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] DIG_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Loads a block, starts, and follows the run. inject_at/reset_at name the
  // post-edge cycle (E_n) after which to disturb the run; -1 disables.
  task automatic run_block(input vec_t v, input int inject_at, input int reset_at);
    int busy_cnt;
    int viol;
    int cyc;
    bit done;
    for (int i = 0; i < 16; i++) begin
      load_in = 1'b1;
      data_in = v.blk[511 - 32*i -: 32];
      tick();
    end
    load_in     = 1'b0;
    data_in     = '0;
    start       = 1'b1;
    cv          = v.cv;
    use_prev_cv = v.use_prev;
    tick();
    start       = 1'b0;
    cv          = 160'hdead_beef_0bad_f00d_1234_5678_9abc_def0_5555_aaaa;
    use_prev_cv = 1'b0;
    check("busy_after_start", 160'(busy), 160'(1));
    check("no_valid_after_start", 160'(out_valid), 160'(0));
    busy_cnt = 1;
    viol     = 0;
    done     = 1'b0;
    cyc      = 0;
    for (int c = 1; c <= 120 && !done; c++) begin
      tick();
      cyc = c;
      if (c == inject_at) begin
        start   = 1'b1;
        load_in = 1'b1;
        data_in = 32'hffff_ffff;
        cv      = '1;
      end else begin
        start   = 1'b0;
        load_in = 1'b0;
        data_in = '0;
      end
      if (c == reset_at) begin
        reset = 1'b0;
        #1;
        check("rst_busy", 160'(busy), 160'(0));
        check("rst_valid", 160'(out_valid), 160'(0));
        check("rst_cv_next", cv_next, 160'(0));
        #2;
        reset = 1'b1;
        return;
      end
      if (out_valid && busy) viol++;
      if (busy) busy_cnt++;
      else done = 1'b1;
    end
    start   = 1'b0;
    load_in = 1'b0;
    if (!done) begin
      check("timeout_busy_never_dropped", 160'(0), 160'(1));
      return;
    end
    check("latency", 160'(cyc), 160'(81));
    check("busy_cycles", 160'(busy_cnt), 160'(81));
    check("valid_pulse", 160'(out_valid), 160'(1));
    check("valid_while_busy", 160'(viol), 160'(0));
    if (v.chk) check("digest", cv_next, v.expd);
    tick();
    check("valid_one_cycle", 160'(out_valid), 160'(0));
    if (v.chk) check("digest_hold", cv_next, v.expd);
  endtask

  initial begin
    vec_t abc;
    reset       = 1'b1;
    data_in     = '0;
    load_in     = 1'b0;
    start       = 1'b0;
    cv          = '0;
    use_prev_cv = 1'b0;

    vecs[0] = '{blk: BLK_ABC, cv: SHA1_IV, use_prev: 1'b0, chk: 1'b1, expd: DIG_ABC};
    vecs[1] = '{blk: {32'h80000000, 480'h0}, cv: SHA1_IV, use_prev: 1'b0, chk: 1'b1,
                expd: DIG_EMPTY};
    vecs[2] = '{blk: {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000},
                cv: SHA1_IV, use_prev: 1'b0, chk: 1'b0, expd: '0};
    vecs[3] = '{blk: {480'h0, 32'h000001c0},
                cv: 160'hffff0000_12345678_deadbeef_cafef00d_0f0f0f0f,
                use_prev: 1'b1, chk: 1'b1, expd: DIG_TWO};

    #1 reset = 1'b0;
    #5;
    check("reset_busy", 160'(busy), 160'(0));
    check("reset_valid", 160'(out_valid), 160'(0));
    check("reset_cv_next", cv_next, 160'(0));
    tick();
    #3 reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_block(vecs[i], -1, -1);

    abc = vecs[0];
    // Start, load and garbage cv presented during round 40 must be ignored.
    run_block(abc, 40, -1);
    // Reset partway through; nothing may be published, then a clean rerun.
    run_block(abc, -1, 30);
    tick();
    check("after_rst_busy", 160'(busy), 160'(0));
    check("after_rst_cv_next", cv_next, 160'(0));
    run_block(abc, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
